// File: rtl/image_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : image_pkg
//  Description : Shared definitions for the image scaling datapath: default
//                frame geometry, RAM address widths, algorithm codes, the
//                frame_buffer_reader FSM state type and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package image_pkg;

  localparam int IMG_W_DEF    = 320;
  localparam int IMG_H_DEF    = 200;
  localparam int SRC_ADDR_W   = 16;
  localparam int DST_ADDR_W   = 16;
  localparam int PIX_W        = 8;
  // FIFO entry layout: {sof, eol, pixel[7:0]}
  localparam int FIFO_ENTRY_W = PIX_W + 2;

  typedef enum logic [1:0] {
    ALG_NN = 2'd0,
    ALG_PR = 2'd1,
    ALG_DC = 2'd2,
    ALG_BA = 2'd3
  } alg_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } fbr_state_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_reader_if
//  Description : Bundles the frame RAM read port and the outgoing pixel
//                stream of frame_buffer_reader.
//  Ports       : rd_addr/rd_en/rd_data  - frame RAM read port
//                pix_data/pix_valid/pix_ready/pix_sof/pix_eol - pixel stream
//  Modports    : master - the reader; slave - RAM model plus pixel consumer
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_buffer_reader_if #(
  parameter int ADDR_W = image_pkg::DST_ADDR_W
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;

  modport master (
    output rd_addr, rd_en,
    input  rd_data,
    output pix_data, pix_valid, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  rd_addr, rd_en,
    output rd_data,
    input  pix_data, pix_valid, pix_sof, pix_eol,
    output pix_ready
  );
endinterface
`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pixel_skid_fifo
//  Description : Two-entry FIFO holding returned pixels with their SOF/EOL
//                tags. The head entry is presented combinationally and stays
//                stable until popped.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_push/i_din  - write strobe and entry
//                i_pop         - remove head entry
//                o_dout        - head entry
//                o_count       - occupancy 0..2
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_skid_fifo
  import image_pkg::*;
#(
  parameter int W = FIFO_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_reader
//  Description : Streams one frame out of the frame RAM in raster order on a
//                valid/ready pixel interface with SOF/EOL markers.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                i_start   - one-cycle pulse, start a frame (accepted in IDLE)
//                o_busy    - frame in progress
//                o_done    - one-cycle pulse after the last pixel handshake
//                bus       - RAM read port and pixel stream (master modport)
//  Revision    : 1.0  initial release
// ============================================================================
module frame_buffer_reader
  import image_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = DST_ADDR_W,
  parameter int RAM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  frame_buffer_reader_if.master bus
);

  localparam int                c_x_w       = cnt_width(IMG_W);
  localparam int                c_y_w       = cnt_width(IMG_H);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [c_x_w-1:0]  c_x_last    = c_x_w'(IMG_W - 1);

  fbr_state_t                r_state;
  fbr_state_t                w_state_nxt;
  logic [c_x_w-1:0]          r_x;
  logic [c_y_w-1:0]          r_y;
  logic [ADDR_W-1:0]         r_addr;
  // Read-latency shadow pipeline: one slot per outstanding RAM cycle.
  logic [RAM_LAT-1:0]        r_pipe_v;
  logic [RAM_LAT-1:0]        r_pipe_sof;
  logic [RAM_LAT-1:0]        r_pipe_eol;
  logic [1:0]                w_fifo_cnt;
  logic [FIFO_ENTRY_W-1:0]   w_fifo_dout;
  logic [7:0]                w_inflight;
  logic [7:0]                w_occ;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_issue;
  logic                      w_last_issue;
  logic                      w_tag_sof;
  logic                      w_tag_eol;

  always_comb begin
    w_inflight = 8'd0;
    for (int i = 0; i < RAM_LAT; i++) begin
      w_inflight = w_inflight + {7'd0, r_pipe_v[i]};
    end
  end

  assign w_pop  = bus.pix_ready && (w_fifo_cnt != 2'd0);
  assign w_push = r_pipe_v[RAM_LAT-1];

  // Occupancy after this cycle's pop; capping it at 2 guarantees every read
  // already in the RAM pipeline has a FIFO slot when it returns, while still
  // allowing one issue per cycle when the consumer keeps up.
  assign w_occ        = {6'd0, w_fifo_cnt} + w_inflight - {7'd0, w_pop};
  assign w_issue      = (r_state == ST_FETCH) && (w_occ < 8'd2);
  assign w_last_issue = w_issue && (r_addr == c_last_addr);
  assign w_tag_sof    = (r_x == '0) && (r_y == '0);
  assign w_tag_eol    = (r_x == c_x_last);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (w_last_issue) w_state_nxt = ST_DRAIN;
      // Leave as the final pixel is handed over so DONE follows it directly.
      ST_DRAIN:  if ((w_inflight == 8'd0) && ((w_fifo_cnt - {1'b0, w_pop}) == 2'd0))
                   w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- address generation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (w_issue) begin
      if (w_last_issue) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
      end else begin
        r_addr <= r_addr + 1'b1;
        if (r_x == c_x_last) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------ read latency tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_v   <= '0;
      r_pipe_sof <= '0;
      r_pipe_eol <= '0;
    end else begin
      r_pipe_v[0]   <= w_issue;
      r_pipe_sof[0] <= w_tag_sof;
      r_pipe_eol[0] <= w_tag_eol;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_sof[i] <= r_pipe_sof[i-1];
        r_pipe_eol[i] <= r_pipe_eol[i-1];
      end
    end
  end

  pixel_skid_fifo #(
    .W (FIFO_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({r_pipe_sof[RAM_LAT-1], r_pipe_eol[RAM_LAT-1], bus.rd_data}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_cnt)
  );

  // ------------------------------------------------------------ outputs
  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = r_addr;
  assign bus.pix_valid = (w_fifo_cnt != 2'd0);
  assign bus.pix_data  = w_fifo_dout[7:0];
  assign bus.pix_eol   = w_fifo_dout[8];
  assign bus.pix_sof   = w_fifo_dout[9];
  assign o_busy        = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign o_done        = (r_state == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_frame_buffer_reader
//  Description : Directed bench for frame_buffer_reader: a 4x3 instance for
//                protocol scenarios and a default 320x200 instance for a
//                full-size frame. RAM models return RAM[a] = a[7:0].
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_buffer_reader;

  logic clk;
  logic rst;
  logic s_start, s_busy, s_done;
  logic b_start, b_busy, b_done;
  int   n_pass  = 0;
  int   n_total = 0;

  frame_buffer_reader_if #(.ADDR_W(16)) s_if ();
  frame_buffer_reader_if #(.ADDR_W(16)) b_if ();

  frame_buffer_reader #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .RAM_LAT(1)) u_small (
    .clk(clk), .rst(rst), .i_start(s_start), .o_busy(s_busy), .o_done(s_done),
    .bus(s_if.master)
  );

  frame_buffer_reader #(.IMG_W(320), .IMG_H(200), .ADDR_W(16), .RAM_LAT(1)) u_big (
    .clk(clk), .rst(rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
    .bus(b_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency frame RAMs holding a ramp.
  always @(posedge clk) if (s_if.rd_en) s_if.rd_data <= s_if.rd_addr[7:0];
  always @(posedge clk) if (b_if.rd_en) b_if.rd_data <= b_if.rd_addr[7:0];

  // ---------------------------------------------------- small-DUT monitor
  logic [9:0] q_pix[$];
  int   mon_reads = 0, mon_done = 0, occ_err = 0, stab_err = 0, outstanding = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_tuple = '0;

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall && (!s_if.pix_valid ||
          ({s_if.pix_sof, s_if.pix_eol, s_if.pix_data} != prev_tuple)))
        stab_err++;
      if (s_if.rd_en) begin
        mon_reads++;
        outstanding++;
      end
      if (s_if.pix_valid && s_if.pix_ready) begin
        q_pix.push_back({s_if.pix_sof, s_if.pix_eol, s_if.pix_data});
        outstanding--;
      end
      if (outstanding > 2) occ_err++;
      if (s_done) mon_done++;
      prev_stall = s_if.pix_valid && !s_if.pix_ready;
      prev_tuple = {s_if.pix_sof, s_if.pix_eol, s_if.pix_data};
    end
  end

  // Expected {sof, eol, data} of pixel i in the 4x3 ramp frame.
  function automatic logic [9:0] exp_px(input int i);
    logic [7:0] d;
    d = 8'(i);
    return {(i == 0), (i % 4 == 3), d};
  endfunction

  function automatic logic [29:0] s_outs();
    return {s_if.rd_addr, s_if.rd_en, s_if.pix_data, s_if.pix_valid,
            s_if.pix_sof, s_if.pix_eol, s_busy, s_done};
  endfunction

  function automatic logic [29:0] b_outs();
    return {b_if.rd_addr, b_if.rd_en, b_if.pix_data, b_if.pix_valid,
            b_if.pix_sof, b_if.pix_eol, b_busy, b_done};
  endfunction

  task automatic pulse_small_start();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
  endtask

  task automatic wait_small_done(input int budget, output bit ok);
    int d0;
    d0 = mon_done;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (mon_done > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_total++;
    if (s_outs() !== 30'd0) $display("FAIL reset_small: got %h want 0", s_outs());
    else n_pass++;
    n_total++;
    if (b_outs() !== 30'd0) $display("FAIL reset_big: got %h want 0", b_outs());
    else n_pass++;
  endtask

  task automatic test_ramp();
    s_if.pix_ready = 1'b1;
    pulse_small_start();
    @(negedge clk);
    n_total++;
    if ({s_busy, s_if.pix_valid} !== 2'b10)
      $display("FAIL ramp_entry busy/valid: got %b want 10", {s_busy, s_if.pix_valid});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (s_if.pix_valid !== 1'b0) $display("FAIL ramp_latency valid: got %b want 0", s_if.pix_valid);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_total++;
      if ({s_if.pix_valid, s_if.pix_sof, s_if.pix_eol, s_if.pix_data} !== {1'b1, exp_px(i)})
        $display("FAIL ramp_px%0d: got v/sof/eol/data %b/%b/%b/%0d want %h",
                 i, s_if.pix_valid, s_if.pix_sof, s_if.pix_eol, s_if.pix_data, {1'b1, exp_px(i)});
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if ({s_done, s_busy} !== 2'b10) $display("FAIL ramp_done done/busy: got %b want 10", {s_done, s_busy});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (s_done !== 1'b0) $display("FAIL ramp_done_pulse: got %b want 0", s_done);
    else n_pass++;
  endtask

  task automatic test_stall_toggle();
    bit got;
    int o0, s0;
    o0 = occ_err; s0 = stab_err;
    got = 1'b0;
    q_pix.delete();
    pulse_small_start();
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      s_if.pix_ready = (k % 3 == 0);
      if (s_done) begin
        got = 1'b1;
        break;
      end
    end
    s_if.pix_ready = 1'b1;
    n_total++;
    if (!got) $display("FAIL stall_done_timeout: got no DONE want DONE");
    else n_pass++;
    n_total++;
    if (q_pix.size() != 12) $display("FAIL stall_count: got %0d want 12", q_pix.size());
    else n_pass++;
    for (int i = 0; i < 12 && i < q_pix.size(); i++) begin
      n_total++;
      if (q_pix[i] !== exp_px(i)) $display("FAIL stall_px%0d: got %h want %h", i, q_pix[i], exp_px(i));
      else n_pass++;
    end
    n_total++;
    if (stab_err != s0) $display("FAIL stall_stable: got %0d changes want 0", stab_err - s0);
    else n_pass++;
    n_total++;
    if (occ_err != o0) $display("FAIL stall_occupancy: got %0d overruns want 0", occ_err - o0);
    else n_pass++;
  endtask

  task automatic test_ready_low();
    bit ok;
    int r0;
    q_pix.delete();
    s_if.pix_ready = 1'b0;
    r0 = mon_reads;
    pulse_small_start();
    repeat (20) @(posedge clk);
    #1;
    n_total++;
    if (mon_reads - r0 != 2) $display("FAIL ready_low_reads: got %0d want 2", mon_reads - r0);
    else n_pass++;
    n_total++;
    if ({s_if.pix_valid, s_if.pix_sof, s_if.pix_data} !== {1'b1, 1'b1, 8'd0})
      $display("FAIL ready_low_head: got v/sof/data %b/%b/%0d want 1/1/0",
               s_if.pix_valid, s_if.pix_sof, s_if.pix_data);
    else n_pass++;
    s_if.pix_ready = 1'b1;
    wait_small_done(100, ok);
    n_total++;
    if (!ok) $display("FAIL ready_low_done_timeout: got no DONE want DONE");
    else n_pass++;
    n_total++;
    if (q_pix.size() != 12) $display("FAIL ready_low_count: got %0d want 12", q_pix.size());
    else n_pass++;
    for (int i = 0; i < 12 && i < q_pix.size(); i++) begin
      n_total++;
      if (q_pix[i] !== exp_px(i)) $display("FAIL ready_low_px%0d: got %h want %h", i, q_pix[i], exp_px(i));
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    bit seen;
    int d0;
    q_pix.delete();
    d0 = mon_done;
    seen = 1'b0;
    s_if.pix_ready = 1'b1;
    pulse_small_start();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      // Pulse once mid-frame and again during the DONE cycle.
      s_start = (k == 5) || s_done;
      if (s_done) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 s_start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    n_total++;
    if (!seen) $display("FAIL ignore_done_timeout: got no DONE want DONE");
    else n_pass++;
    n_total++;
    if (mon_done - d0 != 1) $display("FAIL ignore_done_count: got %0d want 1", mon_done - d0);
    else n_pass++;
    n_total++;
    if (q_pix.size() != 12) $display("FAIL ignore_pixels: got %0d want 12", q_pix.size());
    else n_pass++;
    n_total++;
    if (s_busy !== 1'b0) $display("FAIL ignore_busy: got %b want 0", s_busy);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bit found, ok;
    int d0;
    found = 1'b0;
    s_if.pix_ready = 1'b1;
    pulse_small_start();
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (s_if.pix_valid && (s_if.pix_data == 8'd5)) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found) $display("FAIL midreset_reach_px5: got no pixel 5 want pixel 5");
    else n_pass++;
    rst = 1'b1;
    d0 = mon_done;
    @(posedge clk); #1 rst = 1'b0;
    n_total++;
    if (s_outs() !== 30'd0) $display("FAIL midreset_outputs: got %h want 0", s_outs());
    else n_pass++;
    repeat (10) @(posedge clk);
    #1;
    n_total++;
    if (mon_done != d0) $display("FAIL midreset_no_done: got %0d DONEs want 0", mon_done - d0);
    else n_pass++;
    q_pix.delete();
    pulse_small_start();
    n_total++;
    if (s_if.rd_addr !== 16'd0 || s_if.rd_en !== 1'b1)
      $display("FAIL midreset_restart_addr: got addr/en %0d/%b want 0/1", s_if.rd_addr, s_if.rd_en);
    else n_pass++;
    wait_small_done(100, ok);
    n_total++;
    if (!ok || q_pix.size() != 12) $display("FAIL midreset_frame: got done %b count %0d want 1 12", ok, q_pix.size());
    else n_pass++;
    n_total++;
    if (q_pix.size() == 0 || q_pix[0] !== exp_px(0))
      $display("FAIL midreset_first_px: got %h want %h", (q_pix.size() == 0) ? 10'h3ff : q_pix[0], exp_px(0));
    else n_pass++;
  endtask

  task automatic test_full_frame();
    int pix_cnt, eol_cnt, sof_cnt, data_err, flag_err, n_reads, done_k;
    logic [15:0] last_addr;
    logic [7:0]  d;
    pix_cnt = 0; eol_cnt = 0; sof_cnt = 0; data_err = 0; flag_err = 0; n_reads = 0;
    done_k = -1;
    last_addr = 16'hffff;
    b_if.pix_ready = 1'b1;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      if (b_if.rd_en) begin
        last_addr = b_if.rd_addr;
        n_reads++;
      end
      if (b_if.pix_valid && b_if.pix_ready) begin
        d = 8'(pix_cnt);
        if (b_if.pix_data != d) data_err++;
        if (b_if.pix_eol != (pix_cnt % 320 == 319)) flag_err++;
        if (b_if.pix_sof != (pix_cnt == 0)) flag_err++;
        if (b_if.pix_sof) sof_cnt++;
        if (b_if.pix_eol) eol_cnt++;
        pix_cnt++;
      end
      if (b_done) begin
        done_k = k;
        break;
      end
    end
    n_total++;
    if (done_k != 64002) $display("FAIL full_done_cycle: got %0d want 64002", done_k);
    else n_pass++;
    n_total++;
    if (pix_cnt != 64000) $display("FAIL full_pixels: got %0d want 64000", pix_cnt);
    else n_pass++;
    n_total++;
    if (n_reads != 64000) $display("FAIL full_reads: got %0d want 64000", n_reads);
    else n_pass++;
    n_total++;
    if (last_addr !== 16'd63999) $display("FAIL full_last_addr: got %0d want 63999", last_addr);
    else n_pass++;
    n_total++;
    if (eol_cnt != 200) $display("FAIL full_eol_count: got %0d want 200", eol_cnt);
    else n_pass++;
    n_total++;
    if (sof_cnt != 1) $display("FAIL full_sof_count: got %0d want 1", sof_cnt);
    else n_pass++;
    n_total++;
    if (data_err != 0 || flag_err != 0)
      $display("FAIL full_content: got %0d data / %0d flag errors want 0/0", data_err, flag_err);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    s_start = 1'b0;
    b_start = 1'b0;
    s_if.pix_ready = 1'b1;
    b_if.pix_ready = 1'b1;
    test_reset();
    test_ramp();
    test_stall_toggle();
    test_ready_low();
    test_start_ignored();
    test_reset_midframe();
    test_full_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
